// File: rtl/color_pixel_counter_pkg.sv
// Shared definitions for the RGB332 red/blue pixel counter: field positions,
// widths, FSM states and saturating helpers.
package color_pixel_counter_pkg;

  localparam int unsigned R_MSB = 7;
  localparam int unsigned R_LSB = 5;
  localparam int unsigned G_MSB = 4;
  localparam int unsigned G_LSB = 2;
  localparam int unsigned B_MSB = 1;
  localparam int unsigned B_LSB = 0;

  localparam int unsigned ACC_W = 15;
  localparam int unsigned OUT_W = 10;

  localparam logic [ACC_W-1:0] OUT_MAX = ACC_W'((1 << OUT_W) - 1);

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    COUNT     = 2'd1,
    PUBLISH   = 2'd2
  } state_t;

  function automatic logic [ACC_W-1:0] sat_inc(input logic [ACC_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic [OUT_W-1:0] sat10(input logic [ACC_W-1:0] v);
    return (v > OUT_MAX) ? '1 : v[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/color_pixel_counter_vsync_edge_detect.sv
// Two-flop synchroniser for the camera VSYNC followed by a registered
// rising-edge pulse marking the frame boundary.
module vsync_edge_detect
  import color_pixel_counter_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic VSYNC_IN,
  output logic BND
);

  logic sync_1;
  logic sync_2;
  logic sync_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      sync_d <= 1'b0;
      BND    <= 1'b0;
    end else begin
      sync_1 <= VSYNC_IN;
      sync_2 <= sync_1;
      sync_d <= sync_2;
      BND    <= sync_2 & ~sync_d;
    end
  end

endmodule

// File: rtl/color_pixel_counter.sv
// Classifies RGB332 pixels as red/blue, accumulates per frame and publishes
// scaled, saturated counts with a one-cycle strobe at each good frame boundary.
module color_pixel_counter
  import color_pixel_counter_pkg::*;
#(
  parameter logic [2:0]  RED_MIN    = 3'd5,
  parameter logic [1:0]  BLUE_MIN   = 2'd2,
  parameter int unsigned SHIFT      = 5,
  parameter int unsigned MIN_PIXELS = 1024
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [7:0]       PIXEL_IN,
  input  logic             PIXEL_VALID,
  input  logic             VSYNC_IN,
  output logic [OUT_W-1:0] REDCOUNT,
  output logic [OUT_W-1:0] BLUECOUNT,
  output logic             VGA_VSYNC_NEG,
  output logic             FRAME_ERR
);

  logic bnd;

  vsync_edge_detect u_vsync_edge_detect (
    .CLK      (CLK),
    .RST      (RST),
    .VSYNC_IN (VSYNC_IN),
    .BND      (bnd)
  );

  logic [2:0] pix_r;
  logic [1:0] pix_b;
  logic       is_red;
  logic       is_blue;

  assign pix_r   = PIXEL_IN[R_MSB:R_LSB];
  assign pix_b   = PIXEL_IN[B_MSB:B_LSB];
  assign is_red  = PIXEL_VALID && (pix_r >= RED_MIN) && (pix_b <= 2'd1);
  assign is_blue = PIXEL_VALID && (pix_b >= BLUE_MIN) && (pix_r <= 3'd2);

  state_t           state;
  state_t           state_next;
  logic             frame_start;
  logic             counting;
  logic             publish;
  logic             runt;
  logic [ACC_W-1:0] red_acc;
  logic [ACC_W-1:0] blue_acc;
  logic [ACC_W-1:0] pix_tot;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= WAIT_SYNC;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    frame_start = 1'b0;
    counting    = 1'b0;
    publish     = 1'b0;
    runt        = 1'b0;
    case (state)
      WAIT_SYNC: begin
        if (bnd) begin
          frame_start = 1'b1;
          state_next  = COUNT;
        end
      end
      COUNT: begin
        counting = 1'b1;
        if (bnd) begin
          frame_start = 1'b1;
          if (pix_tot >= ACC_W'(MIN_PIXELS)) begin
            publish    = 1'b1;
            state_next = PUBLISH;
          end else begin
            runt = 1'b1;
          end
        end
      end
      PUBLISH: begin
        counting   = 1'b1;
        state_next = COUNT;
      end
      default: state_next = WAIT_SYNC;
    endcase
  end

  // The snapshot and the clear share the bnd edge, so a pixel valid on that
  // cycle seeds the fresh accumulators instead of the published frame.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      red_acc  <= '0;
      blue_acc <= '0;
      pix_tot  <= '0;
    end else if (frame_start) begin
      red_acc  <= ACC_W'(is_red);
      blue_acc <= ACC_W'(is_blue);
      pix_tot  <= ACC_W'(PIXEL_VALID);
    end else if (counting) begin
      if (is_red)      red_acc  <= sat_inc(red_acc);
      if (is_blue)     blue_acc <= sat_inc(blue_acc);
      if (PIXEL_VALID) pix_tot  <= sat_inc(pix_tot);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      REDCOUNT      <= '0;
      BLUECOUNT     <= '0;
      VGA_VSYNC_NEG <= 1'b0;
      FRAME_ERR     <= 1'b0;
    end else begin
      VGA_VSYNC_NEG <= publish;
      FRAME_ERR     <= runt;
      if (publish) begin
        REDCOUNT  <= sat10(red_acc >> SHIFT);
        BLUECOUNT <= sat10(blue_acc >> SHIFT);
      end
    end
  end

endmodule

// File: tb/tb_color_pixel_counter.sv
// Directed frames for the red/blue pixel counter; expected publish/runt events
// are queued by the stimulus and consumed by an output monitor.
module tb_color_pixel_counter;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] PIXEL_IN;
  logic       PIXEL_VALID;
  logic       VSYNC_IN;
  logic [9:0] REDCOUNT;
  logic [9:0] BLUECOUNT;
  logic       VGA_VSYNC_NEG;
  logic       FRAME_ERR;

  color_pixel_counter #(
    .RED_MIN    (3'd5),
    .BLUE_MIN   (2'd2),
    .SHIFT      (5),
    .MIN_PIXELS (1024)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .PIXEL_IN      (PIXEL_IN),
    .PIXEL_VALID   (PIXEL_VALID),
    .VSYNC_IN      (VSYNC_IN),
    .REDCOUNT      (REDCOUNT),
    .BLUECOUNT     (BLUECOUNT),
    .VGA_VSYNC_NEG (VGA_VSYNC_NEG),
    .FRAME_ERR     (FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       err;
    logic [9:0] red;
    logic [9:0] blue;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest queued expectation.
  always @(negedge CLK) begin
    if (VGA_VSYNC_NEG || FRAME_ERR) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event actual vsync=%0b err=%0b required none",
                 VGA_VSYNC_NEG, FRAME_ERR);
      end else begin
        e = sb.pop_front();
        if (FRAME_ERR !== e.err || VGA_VSYNC_NEG !== !e.err ||
            (!e.err && (REDCOUNT !== e.red || BLUECOUNT !== e.blue))) begin
          failures++;
          $display("FAIL publish actual err=%0b vsync=%0b red=%0d blue=%0d required err=%0b red=%0d blue=%0d",
                   FRAME_ERR, VGA_VSYNC_NEG, REDCOUNT, BLUECOUNT, e.err, e.red, e.blue);
        end
      end
    end
  end

  task automatic send(input int n, input logic [7:0] px);
    repeat (n) begin
      @(negedge CLK);
      PIXEL_VALID = 1'b1;
      PIXEL_IN    = px;
    end
  endtask

  // Raise VSYNC for 8 edges; report edges-to-first-strobe and strobe width.
  task automatic vsync_pulse(output int lat, output int hi);
    lat = 0;
    hi  = 0;
    @(negedge CLK);
    PIXEL_VALID = 1'b0;
    VSYNC_IN    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK);
      #1;
      if (VGA_VSYNC_NEG || FRAME_ERR) begin
        hi++;
        if (lat == 0) lat = i + 1;
      end
    end
    @(negedge CLK);
    VSYNC_IN = 1'b0;
    repeat (6) @(negedge CLK);
  endtask

  int lat;
  int hi;

  initial begin
    RST         = 1'b1;
    PIXEL_IN    = '0;
    PIXEL_VALID = 1'b0;
    VSYNC_IN    = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_red", REDCOUNT, 0);
    chk("reset_blue", BLUECOUNT, 0);
    chk("reset_vsync", VGA_VSYNC_NEG, 0);
    chk("reset_err", FRAME_ERR, 0);
    RST = 1'b0;

    // 1: partial frame after reset is discarded
    send(2000, 8'hE0);
    vsync_pulse(lat, hi);
    chk("t1_no_strobe", hi, 0);
    chk("t1_red", REDCOUNT, 0);
    chk("t1_blue", BLUECOUNT, 0);

    // 2: full red frame, 25344 >> 5 = 792
    sb.push_back('{err: 1'b0, red: 10'd792, blue: 10'd0});
    send(25344, 8'hE0);
    vsync_pulse(lat, hi);
    chk("t2_latency", lat, 4);
    chk("t2_width", hi, 1);

    // 4: runt frame dropped, outputs held
    sb.push_back('{err: 1'b1, red: 10'd0, blue: 10'd0});
    send(500, 8'hE0);
    vsync_pulse(lat, hi);
    chk("t4_err_latency", lat, 4);
    chk("t4_err_width", hi, 1);
    chk("t4_red_held", REDCOUNT, 792);
    chk("t4_blue_held", BLUECOUNT, 0);

    // 3: blue plus green (neither class): 12672 >> 5 = 396
    sb.push_back('{err: 1'b0, red: 10'd0, blue: 10'd396});
    send(12672, 8'h03);
    send(12672, 8'h1C);
    vsync_pulse(lat, hi);
    chk("t3_red", REDCOUNT, 0);
    chk("t3_blue", BLUECOUNT, 396);

    // 5: continuous pixels across bnd, VSYNC rising every 2048 cycles.
    // First boundary closes a 3-pixel runt; then two frames of exactly 2048.
    sb.push_back('{err: 1'b1, red: 10'd0, blue: 10'd0});
    sb.push_back('{err: 1'b0, red: 10'd64, blue: 10'd0});
    sb.push_back('{err: 1'b0, red: 10'd64, blue: 10'd0});
    for (int c = 0; c < 4096 + 24; c++) begin
      @(negedge CLK);
      PIXEL_VALID = 1'b1;
      PIXEL_IN    = 8'hE0;
      VSYNC_IN    = ((c % 2048) < 8);
    end
    @(negedge CLK);
    PIXEL_VALID = 1'b0;
    chk("t5_red", REDCOUNT, 64);

    // 6: reset mid-frame
    send(5000, 8'hE0);
    @(negedge CLK);
    PIXEL_VALID = 1'b0;
    RST = 1'b1;
    #1;
    chk("t6_rst_red", REDCOUNT, 0);
    chk("t6_rst_blue", BLUECOUNT, 0);
    chk("t6_rst_vsync", VGA_VSYNC_NEG, 0);
    chk("t6_rst_err", FRAME_ERR, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    send(2000, 8'hE0);
    vsync_pulse(lat, hi);
    chk("t6_discard", hi, 0);
    sb.push_back('{err: 1'b0, red: 10'd100, blue: 10'd31});
    send(3200, 8'hE0);
    send(1000, 8'h03);
    vsync_pulse(lat, hi);
    chk("t6_latency", lat, 4);
    chk("t6_red", REDCOUNT, 100);
    chk("t6_blue", BLUECOUNT, 31);

    repeat (20) @(negedge CLK);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
